fu_wb_collect: RTL and testbench
================================

# fu_wb_collect

Writeback collector at the output end of the execution functional units (ALU, MUL, DIV, LSU). It absorbs each FU's `fu_output_t` result stream, which carries no backpressure, into a small per-FU FIFO. It arbitrates round-robin onto the single register-file/ROB writeback port and throttles FUs through per-FU stall lines before their FIFO can overflow. A pipeline squash flushes every buffered result.

## Interface

Parameters:
- `NB_FU`, 4: number of FU result streams collected.
- `FIFO_DEPTH`, 2: entries per FU FIFO (power of two, ≥2).
- `SLACK`, 1: results an FU may still emit after sampling its stall line (1 ≤ `SLACK` < `FIFO_DEPTH`).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `fuoutput_i`  in  `NB_FU` x `fu_output_t`  per-FU result `{pc, id, prd, rdval}`.
- `fuoutput_i_valid`  in  `NB_FU`  per-FU result valid; no ready exists, so a valid result is always pushed.
- `fu_stall_o`  out  `NB_FU`  per-FU throttle; gates that FU's `fuinput_i_ready` upstream.
- `wb_o`  out  `fu_output_t`  selected result to regfile/ROB.
- `wb_o_valid`  out  1  writeback valid.
- `wb_i_ready`  in  1  writeback port accepts; may depend combinationally on `wb_o_valid`.
- `overflow_o`  out  1  sticky protocol-error flag.
- `squash_io`  `squash_if.slave`  flush request (`valid`).

## Operation

- **Per-FU FIFO:**
  - `FIFO_DEPTH` entries, with read and write pointers and an occupancy count `cnt[i]` of width `$clog2(FIFO_DEPTH)+1`.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **Push:**
  - Occurs when `fuoutput_i_valid[i]` is high and squash is low.
  - Push into a full FIFO while that FIFO is popped in the same cycle is legal; the count stays at `FIFO_DEPTH`.
  - Push into a full FIFO with no pop drops the result and sets `overflow_o`. The flag is sticky until reset.
- **Stall:** `fu_stall_o[i] = (cnt[i] >= FIFO_DEPTH - SLACK)`, combinational from registered state.
- **Arbitration:**
  - A round-robin pointer `rr_q` (width `$clog2(NB_FU)`) selects the first non-empty FIFO at or after `rr_q`.
  - `wb_o` is that FIFO's head entry.
  - `wb_o_valid` is high when any FIFO is non-empty and squash is low.
- **Pop:**
  - A pop occurs on `wb_o_valid && wb_i_ready`.
  - Only the winner's FIFO is popped.
  - `rr_q` becomes `(winner + 1) mod NB_FU`.
  - With no handshake, `rr_q` holds and `wb_o` stays stable.
- **Squash:**
  - `squash_io.valid` high forces `wb_o_valid` low in that cycle.
  - No pop, and same-cycle inputs are discarded.
  - At the next edge all counts and pointers clear.
  - `rr_q` and `overflow_o` are unaffected.
- **Reset mid-operation:** all state clears immediately (asynchronous); buffered results are lost.
- **Ordering:** results are in order per FU. No cross-FU ordering is guaranteed; the ROB uses `id`.

## Timing

- Reset values:
  - `wb_o_valid` = 0
  - `fu_stall_o` = 0
  - `overflow_o` = 0
  - `rr_q` = 0
  - all counts = 0
  - `wb_o` don't-care (zero preferred).
- Latency, macro off: a result pushed at edge N can be written back in cycle N+1 at the earliest, i.e. 1 cycle of buffering.
- Throughput: one writeback per cycle. Sustained aggregate input above 1 result/cycle must be throttled by stall.
- `fu_stall_o[i]` rises in the cycle after the push that reaches the threshold.
  - The FU must stop issuing in that cycle.
  - Up to `SLACK` already-issued results may still arrive without overflow.

## Configuration

- `FU_WB_BYPASS_EN` defined:
  - When the arbiter's first candidate in round-robin order is an empty FIFO with `fuoutput_i_valid` high, the input is presented on `wb_o` combinationally.
  - If handshaken, it is not pushed.
  - Latency is 0 cycles.
  - Squash still suppresses the bypass.
- Undefined: every result passes through its FIFO. Latency is exactly as in Timing, and there is no combinational path from `fuoutput_i*` to `wb_o*`.

## Test plan

- **Single result:**
  - Stimulus: FU2 pushes `{pc=0x80000010, id=5, prd=12, rdval=0xdeadbeefdeadbeef}`, with `wb_i_ready=1`.
  - Response, macro off: `wb_o_valid` in the next cycle with identical fields.
  - Response, macro on: same cycle.
- **Round-robin fairness:**
  - Stimulus: all 4 FUs push one result in the same cycle, `wb_i_ready=1`.
  - Response: writebacks in order FU0, FU1, FU2, FU3 on 4 consecutive cycles; `rr_q` ends at 0.
- **Backpressure and stall:**
  - Stimulus: `wb_i_ready=0`; FU1 pushes 1 result.
  - Response: `fu_stall_o[1]=1` the next cycle; `wb_o` is stable.
  - Stimulus: a second push arrives.
  - Response: accepted, `cnt=2`, `overflow_o` stays 0.
- **Overflow:**
  - Stimulus: a third push to FU1 while full and `wb_i_ready=0`.
  - Response: result dropped; `overflow_o=1` and it stays 1 until `rst`.
- **Squash:**
  - Stimulus: 3 FIFOs non-empty; assert `squash_io.valid` for 1 cycle together with a new FU0 result.
  - Response: `wb_o_valid=0` that cycle and all following cycles; all `fu_stall_o=0`; FU0's result is lost.
- **Full simultaneous push/pop:**
  - Stimulus: FU3 FIFO full, it wins arbitration with `wb_i_ready=1`, and a push occurs in the same cycle.
  - Response: count stays 2, no overflow, and the next writeback is the older entry.

Source files
------------

// File: rtl/fu_wb_collect_if.sv
// Shared result type for the FU writeback path and the pipeline squash interface.
package fu_wb_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [7:0]  id;
        logic [5:0]  prd;
        logic [63:0] rdval;
    } fu_output_t;
endpackage

interface squash_if;
    logic valid;
    modport master (output valid);
    modport slave  (input  valid);
endinterface

// File: rtl/fu_wb_collect.sv
// Writeback collector: per-FU result FIFOs, round-robin onto one writeback port, stall throttling.
// Optional FU_WB_BYPASS_EN presents an input straight on wb_o when its FIFO is empty and it wins.
module fu_wb_collect
    import fu_wb_pkg::*;
#(
    parameter int NB_FU      = 4,
    parameter int FIFO_DEPTH = 2,
    parameter int SLACK      = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  fu_output_t         fuoutput_i [NB_FU],
    input  logic [NB_FU-1:0]   fuoutput_i_valid,
    output logic [NB_FU-1:0]   fu_stall_o,
    output fu_output_t         wb_o,
    output logic               wb_o_valid,
    input  logic               wb_i_ready,
    output logic               overflow_o,
    squash_if.slave            squash_io
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int RW = (NB_FU > 1) ? $clog2(NB_FU) : 1;

    fu_output_t       mem    [NB_FU][FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr [NB_FU];
    logic [PW-1:0]    rd_ptr [NB_FU];
    logic [CW-1:0]    cnt    [NB_FU];
    logic [RW-1:0]    rr_q;
    logic [RW-1:0]    win;
    logic [RW-1:0]    rr_next;
    logic             squash;
    logic             any_cand;
    logic             bypass_sel;
    logic             handshake;
    logic [NB_FU-1:0] nonempty;
    logic [NB_FU-1:0] full;
    logic [NB_FU-1:0] cand;
    logic [NB_FU-1:0] push;
    logic [NB_FU-1:0] pop;
    logic [NB_FU-1:0] accept;
    logic [NB_FU-1:0] drop;

    assign squash = squash_io.valid;

    always_comb begin
        nonempty   = '0;
        full       = '0;
        fu_stall_o = '0;
        for (int i = 0; i < NB_FU; i++) begin
            nonempty[i]   = (cnt[i] != '0);
            full[i]       = (cnt[i] == CW'(FIFO_DEPTH));
            fu_stall_o[i] = (cnt[i] >= CW'(FIFO_DEPTH - SLACK));
        end
    end

`ifdef FU_WB_BYPASS_EN
    assign cand = nonempty | fuoutput_i_valid;
`else
    assign cand = nonempty;
`endif

    // Arbitration: first candidate at or after rr_q
    always_comb begin
        int idx;
        win      = rr_q;
        any_cand = 1'b0;
        idx      = 0;
        for (int k = 0; k < NB_FU; k++) begin
            idx = (int'(rr_q) + k) % NB_FU;
            if (!any_cand && cand[idx]) begin
                any_cand = 1'b1;
                win      = RW'(idx);
            end
        end
    end

`ifdef FU_WB_BYPASS_EN
    assign bypass_sel = any_cand && !nonempty[win];
`else
    assign bypass_sel = 1'b0;
`endif

    assign wb_o_valid = any_cand && !squash;
    assign handshake  = wb_o_valid && wb_i_ready;
    assign rr_next    = (int'(win) == NB_FU - 1) ? '0 : win + RW'(1);

    always_comb begin
        wb_o = '0;
        if (any_cand) begin
            if (bypass_sel) wb_o = fuoutput_i[win];
            else            wb_o = mem[win][rd_ptr[win]];
        end
    end

    // A bypassed result that is handshaken never enters its FIFO
    always_comb begin
        push   = '0;
        pop    = '0;
        accept = '0;
        drop   = '0;
        for (int i = 0; i < NB_FU; i++) begin
            pop[i]    = handshake && !bypass_sel && (win == RW'(i));
            push[i]   = fuoutput_i_valid[i] && !squash
                        && !(handshake && bypass_sel && (win == RW'(i)));
            drop[i]   = push[i] && full[i] && !pop[i];
            accept[i] = push[i] && !drop[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NB_FU; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
            rr_q       <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (handshake) rr_q <= rr_next;
            if (|drop) overflow_o <= 1'b1;
            for (int i = 0; i < NB_FU; i++) begin
                if (squash) begin
                    wr_ptr[i] <= '0;
                    rd_ptr[i] <= '0;
                    cnt[i]    <= '0;
                end else begin
                    if (accept[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
                    if (pop[i])    rd_ptr[i] <= rd_ptr[i] + PW'(1);
                    if (accept[i] && !pop[i])      cnt[i] <= cnt[i] + CW'(1);
                    else if (pop[i] && !accept[i]) cnt[i] <= cnt[i] - CW'(1);
                end
            end
        end
    end

    // Result storage carries no reset; occupancy is tracked by cnt
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB_FU; i++) begin
            if (accept[i]) mem[i][wr_ptr[i]] <= fuoutput_i[i];
        end
    end

endmodule

// File: tb/tb_fu_wb_collect.sv
// Directed bench for fu_wb_collect: latency, round-robin, stall, overflow, squash, full push/pop.
module tb_fu_wb_collect;
    import fu_wb_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    fu_output_t fo [4];
    logic [3:0] fv = '0;
    logic [3:0] stall;
    fu_output_t wb;
    logic       wb_valid;
    logic       ready = 1'b0;
    logic       ovf;
    int         n_cmp = 0;
    int         n_bad = 0;

    squash_if sq ();

    fu_wb_collect #(.NB_FU(4), .FIFO_DEPTH(2), .SLACK(1)) dut (
        .clk              (clk),
        .rst              (rst),
        .fuoutput_i       (fo),
        .fuoutput_i_valid (fv),
        .fu_stall_o       (stall),
        .wb_o             (wb),
        .wb_o_valid       (wb_valid),
        .wb_i_ready       (ready),
        .overflow_o       (ovf),
        .squash_io        (sq)
    );

    always #5 clk = ~clk;

    function automatic fu_output_t mk(input logic [31:0] pc, input logic [7:0] id,
                                      input logic [5:0] prd, input logic [63:0] v);
        fu_output_t r;
        r.pc = pc; r.id = id; r.prd = prd; r.rdval = v;
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fv = '0;
        ready = 1'b0;
        sq.valid = 1'b0;
        #1;
        check("rst_wb_valid", 128'(wb_valid), 128'(0));
        check("rst_stall", 128'(stall), 128'(0));
        check("rst_overflow", 128'(ovf), 128'(0));
        check("rst_rr", 128'(dut.rr_q), 128'(0));
        check("rst_wb", 128'(wb), 128'(0));
        step();
        rst = 1'b0;
        #1;
    endtask

    fu_output_t a, b1, b2, b3, c1, c2, c3, s0;
    fu_output_t p [4];

    initial begin
        sq.valid = 1'b0;
        for (int i = 0; i < 4; i++) fo[i] = '0;
        a  = mk(32'h8000_0010, 8'd5, 6'd12, 64'hdead_beef_dead_beef);
        b1 = mk(32'h0000_1000, 8'd20, 6'd1, 64'h1111);
        b2 = mk(32'h0000_1004, 8'd21, 6'd2, 64'h2222);
        b3 = mk(32'h0000_1008, 8'd22, 6'd3, 64'h3333);
        c1 = mk(32'h0000_3000, 8'd40, 6'd7, 64'hc1);
        c2 = mk(32'h0000_3004, 8'd41, 6'd8, 64'hc2);
        c3 = mk(32'h0000_3008, 8'd42, 6'd9, 64'hc3);
        s0 = mk(32'h0000_5000, 8'd60, 6'd4, 64'h5555);
        for (int i = 0; i < 4; i++) p[i] = mk(32'h2000 + 32'(i * 4), 8'(10 + i), 6'(20 + i), 64'(100 + i));

        // Single result through FU2
        do_reset();
        ready = 1'b1;
        fo[2] = a;
        fv = 4'b0100;
        #1;
`ifdef FU_WB_BYPASS_EN
        check("single_same_valid", 128'(wb_valid), 128'(1));
        check("single_same_data", 128'(wb), 128'(a));
        step();
        fv = '0;
        #1;
        check("single_after_valid", 128'(wb_valid), 128'(0));
`else
        check("single_same_valid", 128'(wb_valid), 128'(0));
        step();
        fv = '0;
        #1;
        check("single_next_valid", 128'(wb_valid), 128'(1));
        check("single_next_data", 128'(wb), 128'(a));
        step();
        check("single_drained", 128'(wb_valid), 128'(0));
`endif
        check("single_rr", 128'(dut.rr_q), 128'(3));

        // Round-robin fairness
        do_reset();
        ready = 1'b1;
        for (int i = 0; i < 4; i++) fo[i] = p[i];
        fv = 4'b1111;
        step();
        fv = '0;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("rr_valid", 128'(wb_valid), 128'(1));
            check("rr_order", 128'(wb), 128'(p[k]));
            step();
        end
        check("rr_end_valid", 128'(wb_valid), 128'(0));
        check("rr_end_ptr", 128'(dut.rr_q), 128'(0));

        // Backpressure, stall and overflow on FU1
        ready = 1'b0;
        fo[1] = b1;
        fv = 4'b0010;
        step();
        fv = '0;
        #1;
        check("bp_stall", 128'(stall), 128'(4'b0010));
        check("bp_wb", 128'(wb), 128'(b1));
        check("bp_valid", 128'(wb_valid), 128'(1));
        step();
        check("bp_stable", 128'(wb), 128'(b1));
        fo[1] = b2;
        fv = 4'b0010;
        step();
        fv = '0;
        #1;
        check("bp_cnt2", 128'(dut.cnt[1]), 128'(2));
        check("bp_no_ovf", 128'(ovf), 128'(0));
        check("bp_head", 128'(wb), 128'(b1));
        fo[1] = b3;
        fv = 4'b0010;
        step();
        fv = '0;
        #1;
        check("ovf_set", 128'(ovf), 128'(1));
        check("ovf_cnt", 128'(dut.cnt[1]), 128'(2));
        ready = 1'b1;
        #1;
        check("ovf_pop1", 128'(wb), 128'(b1));
        step();
        check("ovf_pop2", 128'(wb), 128'(b2));
        step();
        check("ovf_dropped", 128'(wb_valid), 128'(0));
        check("ovf_sticky", 128'(ovf), 128'(1));

        // Squash with three FIFOs occupied
        ready = 1'b0;
        fo[0] = p[0]; fo[1] = p[1]; fo[2] = p[2];
        fv = 4'b0111;
        step();
        fv = '0;
        #1;
        check("sq_pre_stall", 128'(stall), 128'(4'b0111));
        sq.valid = 1'b1;
        fo[0] = s0;
        fv = 4'b0001;
        #1;
        check("sq_valid_low", 128'(wb_valid), 128'(0));
        step();
        sq.valid = 1'b0;
        fv = '0;
        #1;
        check("sq_after_valid", 128'(wb_valid), 128'(0));
        check("sq_after_stall", 128'(stall), 128'(0));
        check("sq_fu0_lost", 128'(dut.cnt[0]), 128'(0));
        check("sq_ovf_kept", 128'(ovf), 128'(1));
        step();
        check("sq_later_valid", 128'(wb_valid), 128'(0));

        // Full FIFO pushed and popped in the same cycle
        do_reset();
        fo[3] = c1;
        fv = 4'b1000;
        step();
        fo[3] = c2;
        step();
        fv = '0;
        #1;
        check("fp_cnt_full", 128'(dut.cnt[3]), 128'(2));
        check("fp_stall", 128'(stall), 128'(4'b1000));
        ready = 1'b1;
        fo[3] = c3;
        fv = 4'b1000;
        #1;
        check("fp_head", 128'(wb), 128'(c1));
        step();
        fv = '0;
        ready = 1'b0;
        #1;
        check("fp_cnt_kept", 128'(dut.cnt[3]), 128'(2));
        check("fp_no_ovf", 128'(ovf), 128'(0));
        check("fp_older", 128'(wb), 128'(c2));
        ready = 1'b1;
        #1;
        step();
        check("fp_newest", 128'(wb), 128'(c3));
        step();
        check("fp_empty", 128'(wb_valid), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
